// File: rtl/mem_pkg.sv
// Shared types for the multi-cycle memory responder: FSM states and the captured request.
package mem_pkg;
    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} mem_state_t;

    typedef struct packed {
        logic                    we;
        logic [31:0]             addr;
        logic [31:0]             wdata;
        logic [WORD_BYTES-1:0]   be;
    } mem_req_t;
endpackage

// File: rtl/mem_bank.sv
// Word-organised storage split into byte lanes: per-lane synchronous write, registered read.
module mem_bank
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic                      clk,
    input  logic [WORD_BYTES-1:0]     we,
    input  logic                      re,
    input  logic [AW-1:0]             addr,
    input  logic [8*WORD_BYTES-1:0]   wdata,
    output logic [8*WORD_BYTES-1:0]   rdata
);
    genvar gi;
    generate
        for (gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
            // One array per lane so each byte write enable maps onto its own RAM.
            logic [7:0] lane_mem [DEPTH_WORDS];
            logic [7:0] lane_rd_reg;

            always_ff @(posedge clk) begin
                if (we[gi]) begin
                    lane_mem[addr] <= wdata[8*gi +: 8];
                end
                if (re) begin
                    lane_rd_reg <= lane_mem[addr];
                end
            end

            assign rdata[8*gi +: 8] = lane_rd_reg;
        end
    endgenerate
endmodule

// File: rtl/mem_responder.sv
// Multi-cycle memory responder with valid/ready request and response channels and programmable wait states.
// Optional MEM_PERF_CNT_EN adds rd_count/wr_count counters of successful read/write responses.
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_STATES = 2,
    parameter int CNT_W       = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [31:0]             req_addr,
    input  logic [31:0]             req_wdata,
    input  logic [WORD_BYTES-1:0]   req_be,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [31:0]             rsp_rdata,
    output logic                    rsp_err
`ifdef MEM_PERF_CNT_EN
    ,
    output logic [31:0]             rd_count,
    output logic [31:0]             wr_count
`endif
);
    localparam int AW = $clog2(DEPTH_WORDS);

    mem_state_t             state_reg, state_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    mem_req_t               req_reg, req_next;
    logic                   err_reg, err_next;
    logic                   rd_sel_reg, rd_sel_next;
    logic [WORD_BYTES-1:0]  bank_we;
    logic                   bank_re;
    logic [31:0]            bank_rdata;
    logic                   access_err;

    assign access_err = (req_reg.addr[1:0] != 2'b00) ||
                        (req_reg.addr[31:2] >= 30'(DEPTH_WORDS));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            req_reg    <= '0;
            err_reg    <= 1'b0;
            rd_sel_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            req_reg    <= req_next;
            err_reg    <= err_next;
            rd_sel_reg <= rd_sel_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        req_next    = req_reg;
        err_next    = err_reg;
        rd_sel_next = rd_sel_reg;
        bank_we     = '0;
        bank_re     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    req_next = '{we: req_we, addr: req_addr, wdata: req_wdata, be: req_be};
                    if (WAIT_STATES == 0) begin
                        state_next = ACCESS;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = CNT_W'(WAIT_STATES - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_reg == '0) begin
                    state_next = ACCESS;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            ACCESS: begin
                // Errored accesses never reach the bank; reads latch into the bank's read register.
                bank_we     = (req_reg.we && !access_err) ? req_reg.be : '0;
                bank_re     = !req_reg.we && !access_err;
                err_next    = access_err;
                rd_sel_next = !req_reg.we && !access_err;
                state_next  = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next  = IDLE;
                    err_next    = 1'b0;
                    rd_sel_next = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    mem_bank #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_bank (
        .clk   (clk),
        .we    (bank_we),
        .re    (bank_re),
        .addr  (req_reg.addr[AW+1:2]),
        .wdata (req_reg.wdata),
        .rdata (bank_rdata)
    );

    assign req_ready = reset && (state_reg == IDLE);
    assign rsp_valid = (state_reg == RESP);
    assign rsp_err   = err_reg;
    // Gate the bank register so writes, errors and idle cycles present zero data.
    assign rsp_rdata = rd_sel_reg ? bank_rdata : 32'h0;

`ifdef MEM_PERF_CNT_EN
    logic rsp_done;
    assign rsp_done = (state_reg == RESP) && rsp_ready && !err_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_count <= '0;
            wr_count <= '0;
        end else if (rsp_done) begin
            if (req_reg.we) begin
                wr_count <= wr_count + 32'd1;
            end else begin
                rd_count <= rd_count + 32'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: stimulus queues expected responses, a monitor checks each handshake.
module tb_mem_responder;
    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
`ifdef MEM_PERF_CNT_EN
    logic [31:0] rd_count;
    logic [31:0] wr_count;
`endif

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   n_rsp  = 0;

    mem_responder #(
        .DEPTH_WORDS (64),
        .WAIT_STATES (2),
        .CNT_W       (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
`ifdef MEM_PERF_CNT_EN
        ,
        .rd_count  (rd_count),
        .wr_count  (wr_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: one line per completed response handshake.
    always @(negedge clk) begin
        if (reset && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("rsp #%0d: rdata=%h err=%0b (exp %h/%0b)", n_rsp, rsp_rdata, rsp_err, e.rdata, e.err);
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
            end
            n_rsp++;
        end
    end

    task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input logic [31:0] exp_rd, input logic exp_err,
                        input bit chk_lat);
        int t;
        int lat;
        int target;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        exp_q.push_back('{err: exp_err, rdata: exp_rd});
        target = n_rsp + 1;
        @(negedge clk);
        t = 0;
        while (!req_ready && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) chk("accept_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("req_ready_busy", {31'd0, req_ready}, 32'd0);
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        // WAIT_STATES=2: valid seen at the 4th negedge after the accept edge.
        if (chk_lat) chk("rsp_latency", lat, 32'd3);
        t = 0;
        while (n_rsp < target && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (n_rsp < target) chk("rsp_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int t;
        int target;
        reset     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        rsp_ready = 1'b1;

        repeat (3) @(negedge clk);
        chk("reset_req_ready", {31'd0, req_ready}, 32'd0);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        chk("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_req_ready", {31'd0, req_ready}, 32'd1);

        xact(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 32'h0, 1'b0, 1'b1);
        xact(1'b0, 32'h10, 32'h0, 4'b0000, 32'hDEADBEEF, 1'b0, 1'b1);

        xact(1'b1, 32'h20, 32'h11223344, 4'b1111, 32'h0, 1'b0, 1'b0);
        xact(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0, 1'b0);
        xact(1'b0, 32'h20, 32'h0, 4'b0000, 32'h11BB33DD, 1'b0, 1'b0);

        xact(1'b1, 32'h00, 32'hCAFEF00D, 4'b1111, 32'h0, 1'b0, 1'b0);
        xact(1'b1, 32'h100, 32'hFFFFFFFF, 4'b1111, 32'h0, 1'b1, 1'b0);
        xact(1'b0, 32'h00, 32'h0, 4'b1111, 32'hCAFEF00D, 1'b0, 1'b0);

        xact(1'b0, 32'h22, 32'h0, 4'b1111, 32'h0, 1'b1, 1'b1);
        xact(1'b0, 32'h100, 32'h0, 4'b1111, 32'h0, 1'b1, 1'b0);
        xact(1'b1, 32'h21, 32'h0, 4'b1111, 32'h0, 1'b1, 1'b0);
        xact(1'b0, 32'h20, 32'h0, 4'b0000, 32'h11BB33DD, 1'b0, 1'b0);

        xact(1'b1, 32'hFC, 32'h0BADC0DE, 4'b1111, 32'h0, 1'b0, 1'b0);
        xact(1'b0, 32'hFC, 32'h0, 4'b0000, 32'h0BADC0DE, 1'b0, 1'b0);
        xact(1'b1, 32'h20, 32'h99999999, 4'b0000, 32'h0, 1'b0, 1'b0);
        xact(1'b0, 32'h20, 32'h0, 4'b0000, 32'h11BB33DD, 1'b0, 1'b0);

        // Back-pressure: response held 5 cycles while a new request waits.
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h10;
        exp_q.push_back('{err: 1'b0, rdata: 32'hDEADBEEF});
        target = n_rsp + 2;
        @(negedge clk);
        @(posedge clk); #1;
        req_valid = 1'b0;
        t = 0;
        while (!rsp_valid && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (!rsp_valid) chk("hold_rsp_timeout", 32'd1, 32'd0);
        req_valid = 1'b1;
        req_addr  = 32'hFC;
        exp_q.push_back('{err: 1'b0, rdata: 32'h0BADC0DE});
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("hold_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
            chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("hs_cycle_req_ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        chk("post_hs_req_ready", {31'd0, req_ready}, 32'd1);
        chk("post_hs_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("post_hs_rsp_rdata", rsp_rdata, 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        t = 0;
        while (n_rsp < target && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (n_rsp < target) chk("hold_second_timeout", 32'd1, 32'd0);

        // Reset during the WAIT phase of a write drops it.
        xact(1'b1, 32'h30, 32'h0, 4'b1111, 32'h0, 1'b0, 1'b0);
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h30;
        req_wdata = 32'h55AA55AA;
        req_be    = 4'b1111;
        @(negedge clk);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_mid_req_ready", {31'd0, req_ready}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("after_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        end
        chk("after_rst_req_ready", {31'd0, req_ready}, 32'd1);
        xact(1'b0, 32'h30, 32'h0, 4'b0000, 32'h0, 1'b0, 1'b1);

        xact(1'b0, 32'h10, 32'h0, 4'b0000, 32'hDEADBEEF, 1'b0, 1'b0);
        xact(1'b0, 32'h20, 32'h0, 4'b0000, 32'h11BB33DD, 1'b0, 1'b0);
        xact(1'b1, 32'h40, 32'h00000001, 4'b1111, 32'h0, 1'b0, 1'b0);
        xact(1'b1, 32'h44, 32'h00000002, 4'b1111, 32'h0, 1'b0, 1'b0);
        xact(1'b0, 32'h23, 32'h0, 4'b1111, 32'h0, 1'b1, 1'b0);
        xact(1'b0, 32'h40, 32'h0, 4'b0000, 32'h00000001, 1'b0, 1'b0);
`ifdef MEM_PERF_CNT_EN
        // Since the last reset: 4 good reads, 2 good writes, 1 error.
        chk("rd_count", rd_count, 32'd4);
        chk("wr_count", wr_count, 32'd2);
`endif

        repeat (2) @(negedge clk);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
